// File: rtl/prio_encoder_16to4_if.sv
// rtl/prio_encoder_16to4_if.sv - valid/ready code output port of the priority encoder
interface prio_encoder_16to4_if #(
    parameter int CODE_W = 4
);
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;

    modport master (
        output out_valid,
        output out_code,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_code,
        output out_ready
    );
endinterface

// File: rtl/prio_encoder_16to4.sv
// rtl/prio_encoder_16to4.sv - sequential 16-to-4 priority encoder with sticky pending register
module prio_encoder_16to4 #(
    parameter int N_IN      = 16,
    parameter int CODE_W    = 4,
    parameter bit LOW_FIRST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_n,
    input  logic [N_IN-1:0]        req,
    prio_encoder_16to4_if.master   out,
    output logic [N_IN-1:0]        pend,
    output logic                   idle
);
    logic [N_IN-1:0]   pend_q;
    logic [N_IN-1:0]   capture;
    logic [N_IN-1:0]   clear_mask;
    logic [CODE_W-1:0] sel;
    logic [CODE_W-1:0] code_q;
    logic              valid_q;
    logic              load;

    assign capture = en_n ? '0 : req;
    assign load    = (|pend_q) && (!valid_q || out.out_ready);

    // Later loop iterations override earlier ones, so the scan direction sets the winner.
    always_comb begin
        sel = '0;
        if (LOW_FIRST) begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (pend_q[i]) sel = i[CODE_W-1:0];
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (pend_q[i]) sel = i[CODE_W-1:0];
            end
        end
    end

    always_comb begin
        clear_mask = '0;
        if (load) clear_mask[sel] = 1'b1;
    end

    // A fresh request on the line being serviced is OR-ed back in after the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            pend_q <= (pend_q & ~clear_mask) | capture;
            if (load) begin
                valid_q <= 1'b1;
                code_q  <= sel;
            end else if (valid_q && out.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out.out_valid = valid_q;
    assign out.out_code  = code_q;
    assign pend          = pend_q;
    assign idle          = !valid_q && (pend_q == '0);
endmodule
